// File: rtl/axilite_reg_bank.sv
// AXI-lite write-side register bank: collects AW/W in any order, performs one
// byte-masked register write, and returns a B response; one transaction in flight.
module axilite_reg_bank #(
    parameter int                   DATA_SIZE   = 128,
    parameter int                   ADDR_SIZE   = 32,
    parameter int                   DATA_WIDTH  = 32,
    parameter logic [DATA_SIZE-1:0] RESET_VALUE = {DATA_SIZE{1'b0}},
    parameter logic [1:0]           RESP_OKAY   = 2'd0,
    parameter logic [1:0]           RESP_DECERR = 2'd3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_SIZE-1:0]               awaddr,
    input  logic                               awvalid,
    output logic                               awready,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [DATA_WIDTH/8-1:0]            wstrb,
    input  logic                               wvalid,
    output logic                               wready,
    output logic [1:0]                         bresp,
    output logic                               bvalid,
    input  logic                               bready,
    output logic [DATA_SIZE-1:0]               regs,
    output logic [DATA_SIZE/DATA_WIDTH-1:0]    write_strobe
);

    localparam int NUM_REGS = DATA_SIZE / DATA_WIDTH;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int LSB      = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_SIZE - LSB;
    localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

    typedef enum logic [1:0] {
        COLLECT,
        WRITE,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                aw_held;
    logic                w_held;
    logic                aw_hs;
    logic                w_hs;
    logic [IDX_W-1:0]    held_idx;
    logic [DATA_WIDTH-1:0] held_data;
    logic [STRB_W-1:0]   held_strb;

    // Byte-offset address bits do not select anything; the bank is word-addressed.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^awaddr[LSB-1:0];

    always_comb begin
        aw_hs     = awvalid && awready;
        w_hs      = wvalid && wready;
        state_nxt = state;
        case (state)
            COLLECT: if (aw_held && w_held) state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    if (bvalid && bready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs         <= RESET_VALUE;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            write_strobe <= '0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
        end else begin
            write_strobe <= '0;
            case (state)
                COLLECT: begin
                    if (aw_hs) begin
                        held_idx <= awaddr[ADDR_SIZE-1:LSB];
                        aw_held  <= 1'b1;
                    end
                    if (w_hs) begin
                        held_data <= wdata;
                        held_strb <= wstrb;
                        w_held    <= 1'b1;
                    end
                    awready <= !(aw_held || aw_hs);
                    wready  <= !(w_held || w_hs);
                end
                WRITE: begin
                    awready <= 1'b0;
                    wready  <= 1'b0;
                    bvalid  <= 1'b1;
                    if (held_idx < NUM_REGS_IDX) begin
                        bresp <= RESP_OKAY;
                        for (int r = 0; r < NUM_REGS; r++) begin
                            if (held_idx == IDX_W'(r)) begin
                                write_strobe[r] <= |held_strb;
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (held_strb[b])
                                        regs[r*DATA_WIDTH + b*8 +: 8] <= held_data[b*8 +: 8];
                                end
                            end
                        end
                    end else begin
                        bresp <= RESP_DECERR;
                    end
                end
                RESP: begin
                    // Response stays put until the master takes it.
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axilite_reg_bank.md
Name: axilite_reg_bank

Overview:
AXI-lite write-side register bank. It accepts AXI-lite write transactions (AW, W and B channels) and maintains the packed register vector `regs`. The read channel consumes `regs` directly. This block is the single owner and source of the control-register contents seen by the coprocessor and by AXI-lite reads. It also emits a one-cycle per-register update strobe for downstream control logic.

Parameters:
- DATA_SIZE, 128: total register bits; must be a multiple of DATA_WIDTH.
- ADDR_SIZE, 32: awaddr width.
- DATA_WIDTH, 32: bus and register word width; must be 32 or 64.
- RESET_VALUE, {DATA_SIZE{1'b0}}: contents loaded into `regs` on reset.
- RESP_OKAY, 0: bresp code for a successful write.
- RESP_DECERR, 3: bresp code for an out-of-range address.
- Derived (localparam, not a port parameter): NUM_REGS = DATA_SIZE/DATA_WIDTH; STRB_W = DATA_WIDTH/8; LSB = log2(STRB_W).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- awaddr  input  ADDR_SIZE  write byte address.
- awvalid  input  1  address valid.
- awready  output  1  address ready.
- wdata  input  DATA_WIDTH  write data.
- wstrb  input  STRB_W  byte enables.
- wvalid  input  1  data valid.
- wready  output  1  data ready.
- bresp  output  2  write response.
- bvalid  output  1  response valid.
- bready  input  1  response ready.
- regs  output  DATA_SIZE  packed registers; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- write_strobe  output  NUM_REGS  bit i pulses for one cycle when reg i is updated.

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- On reset: regs=RESET_VALUE, awready=0, wready=0, bvalid=0, bresp=RESP_OKAY, write_strobe=0, all held flags cleared, FSM=COLLECT.
- Reset asserted mid-transaction discards any held AW/W and any pending B; no register changes at that edge except the reload to RESET_VALUE.
- All outputs are registered.
- awready and wready first rise at the first clk edge after rst is deasserted.
- COLLECT state:
  - awready = !aw_held; wready = !w_held.
  - An AW handshake (awvalid&&awready at an edge) latches awaddr, sets aw_held and drops awready.
  - A W handshake latches wdata/wstrb, sets w_held and drops wready.
  - AW and W may complete in any order or on the same edge.
  - Once both are held (including the same edge), go to WRITE; awready=wready=0.
- WRITE state (exactly 1 cycle):
  - idx = held_addr[ADDR_SIZE-1:LSB]; addr[LSB-1:0] is ignored.
  - If idx < NUM_REGS: for each byte b with wstrb[b]=1, update byte b of reg idx; bresp=RESP_OKAY; write_strobe[idx]=1 for one cycle if wstrb != 0.
  - If idx >= NUM_REGS: no register change; bresp=RESP_DECERR; write_strobe stays 0.
  - At the same edge, bvalid=1; go to RESP.
- Latency: the new regs value and bvalid are both visible 2 edges after the final AW/W handshake edge.
- RESP state:
  - bvalid and bresp are held stable until bready.
  - On the bvalid&&bready edge: bvalid=0, held flags cleared, awready=wready=1, go to COLLECT.
  - No new AW/W is accepted while in WRITE or RESP (one outstanding transaction).
- Register values change only in WRITE or on reset; they are stable at all other times.
- The read channel sees a new value at the same edge bvalid rises, so a read issued after B completes returns the new data.

Test Plan:
- Reset: assert rst for 2 cycles -> regs==RESET_VALUE, bvalid=0, awready=wready=0 during reset, both =1 one cycle after release.
- Simultaneous full write: AW=0x4 and W=0xDEADBEEF, wstrb=0xF, same edge -> reg1=0xDEADBEEF and bvalid=1 with bresp=0 two edges later; write_strobe=4'b0010 for one cycle; other regs unchanged.
- Split order with partial strobe: W=0x11223344, wstrb=0x5 first, AW=0x8 three cycles later -> wready low while waiting; reg2 bytes 0 and 2 become 0x44 and 0x22, bytes 1 and 3 keep their prior value.
- Out of range: AW=0x10 (DATA_SIZE=128), W=0xFFFFFFFF -> bresp=3 (DECERR), all regs unchanged, write_strobe=0.
- Backpressure: bready held low for 5 cycles -> bvalid/bresp stable for all 5, awready/wready stay 0 and a new awvalid is not accepted; after the B handshake, awready=wready=1 on the next cycle.
- Reset mid-transaction: AW held, W not yet sent, rst pulsed for 1 cycle -> aw_held cleared, no write occurs, and a subsequent W alone does not trigger bvalid.
